// File: rtl/rr_mux.sv
// Registered round-robin valid/ready multiplexer for CHANNELS input streams.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last word.
module rr_mux #(
  parameter int N        = 32,
  parameter int CHANNELS = 8,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS-1:0]   in_last,
  output logic [CHANNELS-1:0]   in_ready,
  output logic [N-1:0]          out_data,
  output logic [SW-1:0]         out_sel,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

  logic [SW-1:0]       ptr;
  logic [SW-1:0]       ptr_nx;
  logic [SW-1:0]       grant;
  logic [CHANNELS-1:0] elig;
  logic                any;
  logic                load;
  logic                xfer;

  assign load = !out_valid || out_ready;
  assign xfer = load && any && !rst;

`ifdef RR_MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_t;

  lock_t         state;
  lock_t         state_nx;
  logic [SW-1:0] lock_ch;
  logic [SW-1:0] lock_ch_nx;

  always_comb begin
    if (state == LOCKED) elig = in_valid & (ONE << lock_ch);
    else elig = in_valid;
  end

  always_comb begin
    state_nx   = state;
    lock_ch_nx = lock_ch;
    if (xfer) begin
      if (state == IDLE && !in_last[grant]) begin
        state_nx   = LOCKED;
        lock_ch_nx = grant;
      end else if (state == LOCKED && in_last[grant]) begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nx;
      lock_ch <= lock_ch_nx;
    end
  end
`else
  assign elig = in_valid;
`endif

  // Walk offsets from the top down so the closest eligible channel to ptr wins.
  always_comb begin
    int idx;
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (elig[idx]) begin
        any   = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  assign ptr_nx   = (grant == SW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
  assign in_ready = xfer ? (ONE << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*N +: N];
        out_sel   <= grant;
        out_last  <= in_last[grant];
        ptr       <= ptr_nx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux (CHANNELS=8, N=32).
// Lock expectations follow RR_MUX_LOCK_EN when it is defined for the build.
module tb_rr_mux;

  localparam int N  = 32;
  localparam int CH = 8;
  localparam int SW = 3;

  logic            clk;
  logic            rst;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_last;
  logic [CH-1:0]   in_ready;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  int n_chk;
  int n_pass;

  rr_mux #(.N(N), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sel_exp  [4];
  int last_exp [4];
  int ch2_cnt;
  int e;

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 8'hFF;
    in_last   = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = 32'h100 + i;

    // reset held two cycles with every channel valid
    step();
    chk("rst_ready", in_ready, 0);
    step();
    chk("rst_ready2", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_last", out_last, 0);

    // rotation 0..7,0
    rst = 1'b0;
    #1;
    chk("first_grant", in_ready, 8'h01);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rot_valid", out_valid, 1);
      chk("rot_sel", out_sel, i % 8);
      chk("rot_data", out_data, 32'h100 + (i % 8));
      chk("rot_ready", in_ready, 64'(1) << ((i + 1) % 8));
    end

    // backpressure with only channel 3 valid
    in_valid  = 8'h08;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h100);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 8'h08);
    step();
    chk("bp_sel", out_sel, 3);
    chk("bp_data2", out_data, 32'h103);

    // channel 6 alone moves ptr to 7, then 6 and 1 alternate
    in_valid = 8'h40;
    #1;
    chk("sp_ready6", in_ready, 8'h40);
    step();
    chk("sp_sel6", out_sel, 6);
    in_valid = 8'h42;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 1 : 6;
      #1;
      chk("wrap_ready", in_ready, 64'(1) << e);
      step();
      chk("wrap_sel", out_sel, e);
      chk("wrap_data", out_data, 32'h100 + e);
    end

    // idle gap
    in_valid = 8'h00;
    #1;
    chk("idle_ready", in_ready, 0);
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 32'h106);
    chk("idle_sel", out_sel, 6);

    // channel 1 alone puts ptr at 2
    in_valid = 8'h02;
    step();
    chk("pre_lock_sel", out_sel, 1);

`ifdef RR_MUX_LOCK_EN
    sel_exp  = '{2, 2, 2, 3};
    last_exp = '{0, 0, 1, 1};
`else
    sel_exp  = '{2, 3, 4, 5};
    last_exp = '{0, 1, 1, 1};
`endif
    // channel 2 sends a 3-word burst while every channel is valid
    in_valid = 8'hFF;
    ch2_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      in_last    = 8'hFF;
      in_last[2] = (ch2_cnt >= 2);
      #1;
      chk("lock_ready", in_ready, 64'(1) << sel_exp[i]);
      step();
      if (out_sel == 2) ch2_cnt++;
      chk("lock_sel", out_sel, sel_exp[i]);
      chk("lock_last", out_last, last_exp[i]);
    end

    // reset discards an in-flight word
    in_last   = 8'hFF;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant", in_ready, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
